// File: rtl/npc_fetch_pc.sv
// ---------------------------------------------------------------------------
// npc_fetch_pc
//
// Fetch-stage program counter and next-PC unit for the five-stage MIPS
// pipeline. The unit resolves branches and jumps in D from the D-stage
// compare flags, owns the F-stage PC register, and supplies the link
// address and the conditional-link enable used by bgezalr. The branch
// delay slot is architectural. F already holds D_pc+4 when a redirect
// is decided, so a taken target takes effect after the delay slot.
//
// Optional feature macro: NPC_BRANCH_STAT_EN
//   When this macro is defined, the unit adds two saturating statistics
//   counters: branches committed and branches taken.
//
// Parameters:
//   PC_RESET        F_pc value after reset (default 32'h0000_3000)
//
// Ports:
//   clk             system clock, rising edge
//   reset           asynchronous, active-high reset
//   stall           hazard stall; F_pc holds and no D decision commits
//   D_pc            PC of the instruction in D
//   D_imm16         branch offset field
//   D_instr_index   j/jal index field
//   D_rs_val        forwarded GPR[rs]; target for jr/jalr/bgezalr
//   D_br_type       branch/jump class (0 none, 1 beq, 2 bne, 3 bgez,
//                   4 bgtz, 5 blez, 6 bltz, 7 j/jal, 8 jr/jalr,
//                   9 bgezalr, 10-15 none)
//   D_equal         rs == rt
//   D_equal_0       rs == 0
//   D_great_0       rs > 0 (signed)
//   F_pc            current fetch address
//   D_taken         combinational taken decision for D
//   D_link_pc       D_pc + 8
//   D_link_en       1 only for a taken bgezalr
//   stat_br_cnt     (NPC_BRANCH_STAT_EN) committed conditional branches
//   stat_taken_cnt  (NPC_BRANCH_STAT_EN) committed taken conditional branches
// ---------------------------------------------------------------------------
module npc_fetch_pc #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] D_pc,
    input  logic [15:0] D_imm16,
    input  logic [25:0] D_instr_index,
    input  logic [31:0] D_rs_val,
    input  logic [3:0]  D_br_type,
    input  logic        D_equal,
    input  logic        D_equal_0,
    input  logic        D_great_0,
`ifdef NPC_BRANCH_STAT_EN
    output logic [31:0] stat_br_cnt,
    output logic [31:0] stat_taken_cnt,
`endif
    output logic [31:0] F_pc,
    output logic        D_taken,
    output logic [31:0] D_link_pc,
    output logic        D_link_en
);

    localparam logic [3:0] BR_NONE    = 4'd0;
    localparam logic [3:0] BR_BEQ     = 4'd1;
    localparam logic [3:0] BR_BNE     = 4'd2;
    localparam logic [3:0] BR_BGEZ    = 4'd3;
    localparam logic [3:0] BR_BGTZ    = 4'd4;
    localparam logic [3:0] BR_BLEZ    = 4'd5;
    localparam logic [3:0] BR_BLTZ    = 4'd6;
    localparam logic [3:0] BR_J       = 4'd7;
    localparam logic [3:0] BR_JR      = 4'd8;
    localparam logic [3:0] BR_BGEZALR = 4'd9;

    logic [31:0] imm_offset;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] target;
    logic [31:0] next_pc;
    logic        ge_zero;

    // Sign-extended word offset; all adds wrap modulo 2^32.
    assign imm_offset    = {{14{D_imm16[15]}}, D_imm16, 2'b00};
    assign branch_target = D_pc + 32'd4 + imm_offset;
    assign jump_target   = {D_pc[31:28], D_instr_index, 2'b00};
    assign ge_zero       = D_equal_0 | D_great_0;
    assign D_link_pc     = D_pc + 32'd8;

    // Taken decision and target selection for the D instruction.
    always_comb begin
        D_taken = 1'b0;
        target  = branch_target;
        case (D_br_type)
            BR_BEQ:     D_taken = D_equal;
            BR_BNE:     D_taken = ~D_equal;
            BR_BGEZ:    D_taken = ge_zero;
            BR_BGTZ:    D_taken = D_great_0;
            BR_BLEZ:    D_taken = ~D_great_0;
            BR_BLTZ:    D_taken = ~ge_zero;
            BR_J: begin
                D_taken = 1'b1;
                target  = jump_target;
            end
            BR_JR: begin
                D_taken = 1'b1;
                target  = D_rs_val;
            end
            BR_BGEZALR: begin
                D_taken = ge_zero;
                target  = D_rs_val;
            end
            default:    D_taken = 1'b0;
        endcase
    end

    assign D_link_en = (D_br_type == BR_BGEZALR) && D_taken;
    assign next_pc   = D_taken ? target : (F_pc + 32'd4);

    // The F-stage PC advances only on unstalled edges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            F_pc <= PC_RESET;
        end else if (!stall) begin
            F_pc <= next_pc;
        end
    end

`ifdef NPC_BRANCH_STAT_EN
    logic is_cond_branch;

    // Jumps (7, 8) and non-branches are excluded from the statistics.
    assign is_cond_branch = ((D_br_type >= BR_BEQ) && (D_br_type <= BR_BLTZ)) ||
                            (D_br_type == BR_BGEZALR);

    // Saturating counters so a long run never wraps back to small values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_br_cnt    <= 32'd0;
            stat_taken_cnt <= 32'd0;
        end else if (!stall && is_cond_branch) begin
            if (stat_br_cnt != 32'hFFFF_FFFF) begin
                stat_br_cnt <= stat_br_cnt + 32'd1;
            end
            if (D_taken && (stat_taken_cnt != 32'hFFFF_FFFF)) begin
                stat_taken_cnt <= stat_taken_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_npc_fetch_pc.sv
// ---------------------------------------------------------------------------
// tb_npc_fetch_pc
//
// Directed testbench for npc_fetch_pc. Each scenario task drives its own
// stimulus and compares against hand-computed values.
// ---------------------------------------------------------------------------
module tb_npc_fetch_pc;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [31:0] D_pc;
    logic [15:0] D_imm16;
    logic [25:0] D_instr_index;
    logic [31:0] D_rs_val;
    logic [3:0]  D_br_type;
    logic        D_equal;
    logic        D_equal_0;
    logic        D_great_0;
    logic [31:0] F_pc;
    logic        D_taken;
    logic [31:0] D_link_pc;
    logic        D_link_en;
`ifdef NPC_BRANCH_STAT_EN
    logic [31:0] stat_br_cnt;
    logic [31:0] stat_taken_cnt;
`endif

    int checks;
    int errors;

    npc_fetch_pc dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .D_pc          (D_pc),
        .D_imm16       (D_imm16),
        .D_instr_index (D_instr_index),
        .D_rs_val      (D_rs_val),
        .D_br_type     (D_br_type),
        .D_equal       (D_equal),
        .D_equal_0     (D_equal_0),
        .D_great_0     (D_great_0),
`ifdef NPC_BRANCH_STAT_EN
        .stat_br_cnt   (stat_br_cnt),
        .stat_taken_cnt(stat_taken_cnt),
`endif
        .F_pc          (F_pc),
        .D_taken       (D_taken),
        .D_link_pc     (D_link_pc),
        .D_link_en     (D_link_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic [3:0] br_type, input logic [31:0] pc,
                         input logic eq, input logic eq0, input logic gt0);
        D_br_type = br_type;
        D_pc      = pc;
        D_equal   = eq;
        D_equal_0 = eq0;
        D_great_0 = gt0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        stall = 1'b0;
        set_d(4'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        D_imm16 = 16'h0; D_instr_index = 26'h0; D_rs_val = 32'h0;
        #2;
        checks++;
        if (F_pc !== 32'h0000_3000) begin
            errors++;
            $display("[TB] FAIL reset_pc: got %h expected %h", F_pc, 32'h0000_3000);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (F_pc !== 32'h0000_3000) begin
            errors++;
            $display("[TB] FAIL release_pc: got %h expected %h", F_pc, 32'h0000_3000);
        end
        repeat (3) tick();
        checks++;
        if (F_pc !== 32'h0000_300C) begin
            errors++;
            $display("[TB] FAIL seq_fetch: got %h expected %h", F_pc, 32'h0000_300C);
        end
    endtask

    task automatic test_beq();
        D_imm16 = 16'hFFFF;
        set_d(4'd1, 32'h0000_3004, 1'b1, 1'b0, 1'b0);
        checks++;
        if (D_taken !== 1'b1) begin
            errors++;
            $display("[TB] FAIL beq_taken: got %b expected 1", D_taken);
        end
        checks++;
        if (D_link_pc !== 32'h0000_300C) begin
            errors++;
            $display("[TB] FAIL beq_link_pc: got %h expected %h", D_link_pc, 32'h0000_300C);
        end
        tick();
        checks++;
        if (F_pc !== 32'h0000_3004) begin
            errors++;
            $display("[TB] FAIL beq_target: got %h expected %h", F_pc, 32'h0000_3004);
        end
        set_d(4'd1, 32'h0000_3004, 1'b0, 1'b0, 1'b0);
        checks++;
        if (D_taken !== 1'b0) begin
            errors++;
            $display("[TB] FAIL beq_not_taken: got %b expected 0", D_taken);
        end
        tick();
        checks++;
        if (F_pc !== 32'h0000_3008) begin
            errors++;
            $display("[TB] FAIL beq_fallthrough: got %h expected %h", F_pc, 32'h0000_3008);
        end
    endtask

    // Conditions for types 2-6 and an unused type, flags {eq, eq0, gt0}.
    task automatic test_conditions();
        logic [3:0] types [12] = '{4'd2, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4, 4'd4,
                                   4'd5, 4'd5, 4'd6, 4'd6, 4'd12};
        logic [2:0] flags [12] = '{3'b100, 3'b000, 3'b010, 3'b001, 3'b000, 3'b001, 3'b010,
                                   3'b010, 3'b001, 3'b000, 3'b001, 3'b111};
        logic       expect_taken [12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0,
                                          1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] held;
        stall = 1'b1;
        D_imm16 = 16'h0010;
        held = F_pc;
        for (int i = 0; i < 12; i++) begin
            set_d(types[i], 32'h0000_4000, flags[i][2], flags[i][1], flags[i][0]);
            checks++;
            if (D_taken !== expect_taken[i] || D_link_en !== 1'b0) begin
                errors++;
                $display("[TB] FAIL cond_%0d type %0d: got taken=%b link_en=%b expected taken=%b link_en=0",
                         i, types[i], D_taken, D_link_en, expect_taken[i]);
            end
        end
        tick();
        checks++;
        if (F_pc !== held) begin
            errors++;
            $display("[TB] FAIL stall_hold: got %h expected %h", F_pc, held);
        end
        // bne taken with a positive offset: 0x4000 + 4 + 0x40.
        set_d(4'd2, 32'h0000_4000, 1'b0, 1'b0, 1'b0);
        stall = 1'b0;
        tick();
        checks++;
        if (F_pc !== 32'h0000_4044) begin
            errors++;
            $display("[TB] FAIL bne_target: got %h expected %h", F_pc, 32'h0000_4044);
        end
    endtask

    task automatic test_bgezalr();
        D_rs_val = 32'h0000_3100;
        set_d(4'd9, 32'h0000_3008, 1'b0, 1'b0, 1'b1);
        checks++;
        if (D_taken !== 1'b1 || D_link_en !== 1'b1 || D_link_pc !== 32'h0000_3010) begin
            errors++;
            $display("[TB] FAIL bgezalr_taken: got taken=%b link_en=%b link_pc=%h expected 1 1 %h",
                     D_taken, D_link_en, D_link_pc, 32'h0000_3010);
        end
        tick();
        checks++;
        if (F_pc !== 32'h0000_3100) begin
            errors++;
            $display("[TB] FAIL bgezalr_target: got %h expected %h", F_pc, 32'h0000_3100);
        end
        D_rs_val = 32'h8000_0000;
        set_d(4'd9, 32'h0000_30FC, 1'b0, 1'b0, 1'b0);
        checks++;
        if (D_taken !== 1'b0 || D_link_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bgezalr_neg: got taken=%b link_en=%b expected 0 0", D_taken, D_link_en);
        end
        tick();
        checks++;
        if (F_pc !== 32'h0000_3104) begin
            errors++;
            $display("[TB] FAIL bgezalr_fallthrough: got %h expected %h", F_pc, 32'h0000_3104);
        end
    endtask

    task automatic test_stall_jump();
        D_instr_index = 26'h0000C40;
        set_d(4'd7, 32'h5000_0010, 1'b0, 1'b0, 1'b0);
        stall = 1'b1;
        repeat (2) tick();
        checks++;
        if (F_pc !== 32'h0000_3104) begin
            errors++;
            $display("[TB] FAIL jump_stall_hold: got %h expected %h", F_pc, 32'h0000_3104);
        end
        stall = 1'b0;
        tick();
        checks++;
        if (F_pc !== 32'h5000_3100) begin
            errors++;
            $display("[TB] FAIL jump_target: got %h expected %h", F_pc, 32'h5000_3100);
        end
    endtask

    task automatic test_wrap_reset();
        D_rs_val = 32'hFFFF_FFFC;
        set_d(4'd8, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
        tick();
        checks++;
        if (F_pc !== 32'hFFFF_FFFC) begin
            errors++;
            $display("[TB] FAIL jr_target: got %h expected %h", F_pc, 32'hFFFF_FFFC);
        end
        set_d(4'd0, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
        tick();
        checks++;
        if (F_pc !== 32'h0000_0000) begin
            errors++;
            $display("[TB] FAIL pc_wrap: got %h expected %h", F_pc, 32'h0000_0000);
        end
        // Reset mid-stall with a taken jump pending; no edge in between.
        set_d(4'd8, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
        stall = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (F_pc !== 32'h0000_3000) begin
            errors++;
            $display("[TB] FAIL async_reset: got %h expected %h", F_pc, 32'h0000_3000);
        end
        @(negedge clk);
        reset = 1'b0;
        stall = 1'b0;
        set_d(4'd0, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
        tick();
        checks++;
        if (F_pc !== 32'h0000_3004) begin
            errors++;
            $display("[TB] FAIL post_reset_fetch: got %h expected %h", F_pc, 32'h0000_3004);
        end
    endtask

`ifdef NPC_BRANCH_STAT_EN
    task automatic test_stats();
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (stat_br_cnt !== 32'd0 || stat_taken_cnt !== 32'd0) begin
            errors++;
            $display("[TB] FAIL stat_reset: got %0d/%0d expected 0/0", stat_br_cnt, stat_taken_cnt);
        end
        reset = 1'b0;
        stall = 1'b0;
        D_imm16 = 16'h0004;
        set_d(4'd1, 32'h0000_3000, 1'b1, 1'b0, 1'b0); tick();
        set_d(4'd2, 32'h0000_3000, 1'b1, 1'b0, 1'b0); tick();
        set_d(4'd4, 32'h0000_3000, 1'b0, 1'b0, 1'b1); tick();
        set_d(4'd6, 32'h0000_3000, 1'b0, 1'b1, 1'b0); tick();
        set_d(4'd7, 32'h0000_3000, 1'b0, 1'b0, 1'b0); tick();
        set_d(4'd9, 32'h0000_3000, 1'b0, 1'b1, 1'b0); tick();
        stall = 1'b1;
        set_d(4'd1, 32'h0000_3000, 1'b1, 1'b0, 1'b0); tick();
        set_d(4'd3, 32'h0000_3000, 1'b0, 1'b1, 1'b0); tick();
        stall = 1'b0;
        set_d(4'd0, 32'h0000_3000, 1'b0, 1'b0, 1'b0); tick();
        checks++;
        if (stat_br_cnt !== 32'd5 || stat_taken_cnt !== 32'd3) begin
            errors++;
            $display("[TB] FAIL stat_counts: got %0d/%0d expected 5/3", stat_br_cnt, stat_taken_cnt);
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_beq();
        test_conditions();
        test_bgezalr();
        test_stall_jump();
        test_wrap_reset();
`ifdef NPC_BRANCH_STAT_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
